// File: rtl/fp12_dot_accum.sv
// fp12_dot_accum
//   Dot-product accumulator for the four FP12 product lanes produced by the
//   FP8 vector multiplier. Each beat's lanes are converted to signed fixed
//   point (LSB = 2^-21), summed by a four-lane adder tree, and accumulated
//   across beats until in_last. One result is emitted per vector.
//
//   Lane format: {sign, exp[4:0], mant[5:0]}, value = (-1)^s * 1.mant * 2^(exp-15).
//   exp=0 is zero; exp=31 is inf/saturated and contributes 0 but flags out_inf.
//
//   Pipeline: S1 lane conversion -> S2 adder tree -> S3 accumulator -> result
//   register. A last beat sampled at edge t shows out_valid after edge t+3.
//
//   Optional build macro FP12ACC_SAT_EN: when defined, accumulator overflow
//   clamps to the signed limit and holds for the rest of the vector. When
//   undefined, the accumulator wraps modulo 2^ACC_W. out_ovf flags either case.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   in_valid   product beat valid
//   in_last    final beat of the vector (qualified by in_valid)
//   pa..pd     product lanes 0..3, 12 bits each
//   out_valid  one-cycle result strobe
//   out_sum    signed fixed-point dot product (ACC_W bits, LSB 2^-21); 0 if out_inf
//   out_inf    some lane in the vector had exp=31
//   out_ovf    accumulator signed overflow occurred in the vector
//   out_beats  valid beats in the vector, saturating at 2^CNT_W-1

module fp12_dot_accum #(
  parameter int ACC_W = 48,  // must be >= 40
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [11:0]      pa,
  input  logic [11:0]      pb,
  input  logic [11:0]      pc,
  input  logic [11:0]      pd,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_inf,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_beats
);

  // Largest lane magnitude is 127 << 30 (37 bits), plus sign -> 38 bits.
  // Four lanes add two more bits of headroom -> 40 bits.
  localparam int LANE_W = 38;
  localparam int TREE_W = 40;

  function automatic logic signed [LANE_W-1:0] lane_to_fix(input logic [11:0] p);
    logic [4:0]        e;
    logic [LANE_W-1:0] mag;
    e   = p[10:6];
    mag = '0;
    if (e != 5'd0 && e != 5'd31)
      mag = {{(LANE_W-7){1'b0}}, 1'b1, p[5:0]} << e;
    return p[11] ? -mag : mag;
  endfunction

  function automatic logic lane_is_inf(input logic [11:0] p);
    return p[10:6] == 5'd31;
  endfunction

  // ---------------- S1: per-lane conversion ----------------
  logic                     s1_valid, s1_last, s1_inf;
  logic signed [LANE_W-1:0] s1_lane [4];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_inf   <= 1'b0;
      // NOTE: this is a four-entry register bank, not a RAM, so it is reset
      // along with the rest of the pipeline; RAM-backed arrays would not be.
      for (int i = 0; i < 4; i++) s1_lane[i] <= '0;
    end else begin
      s1_valid   <= in_valid;
      s1_last    <= in_valid & in_last;
      s1_inf     <= lane_is_inf(pa) | lane_is_inf(pb) | lane_is_inf(pc) | lane_is_inf(pd);
      s1_lane[0] <= lane_to_fix(pa);
      s1_lane[1] <= lane_to_fix(pb);
      s1_lane[2] <= lane_to_fix(pc);
      s1_lane[3] <= lane_to_fix(pd);
    end
  end

  // ---------------- S2: adder tree ----------------
  logic signed [TREE_W-1:0] tree_sum;

  // NOTE: combinational blocks assign every output unconditionally so no
  // latch can be inferred.
  always_comb begin
    tree_sum = TREE_W'(s1_lane[0]) + TREE_W'(s1_lane[1])
             + TREE_W'(s1_lane[2]) + TREE_W'(s1_lane[3]);
  end

  logic             s2_valid, s2_last, s2_inf;
  logic [ACC_W-1:0] s2_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_inf   <= 1'b0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_inf   <= s1_inf;
      s2_sum   <= ACC_W'(tree_sum);  // signed cast sign-extends
    end
  end

  // ---------------- S3: accumulator ----------------
  logic             first_beat;
  logic [ACC_W-1:0] acc;
  logic             inf_st, ovf_st;
  logic [CNT_W-1:0] beat_cnt;
  logic             s3_done;

  logic [ACC_W-1:0] acc_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] beat_inc;

  always_comb begin
    acc_sum  = acc + s2_sum;
    // Same-sign operands producing a different-sign result.
    add_ovf  = (acc[ACC_W-1] == s2_sum[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    beat_inc = (beat_cnt == {CNT_W{1'b1}}) ? beat_cnt : beat_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_beat <= 1'b1;
      acc        <= '0;
      inf_st     <= 1'b0;
      ovf_st     <= 1'b0;
      beat_cnt   <= '0;
      s3_done    <= 1'b0;
    end else begin
      s3_done <= s2_valid & s2_last;
      if (s2_valid) begin
        first_beat <= s2_last;
        if (first_beat) begin
          // A tree sum always fits, so the first beat can never overflow.
          acc      <= s2_sum;
          inf_st   <= s2_inf;
          ovf_st   <= 1'b0;
          beat_cnt <= CNT_W'(1);
        end else begin
          inf_st   <= inf_st | s2_inf;
          beat_cnt <= beat_inc;
`ifdef FP12ACC_SAT_EN
          if (ovf_st) begin
            acc <= acc;  // stay clamped until the vector ends
          end else if (add_ovf) begin
            acc    <= acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
            ovf_st <= 1'b1;
          end else begin
            acc <= acc_sum;
          end
`else
          acc <= acc_sum;
          if (add_ovf) ovf_st <= 1'b1;
`endif
        end
      end
    end
  end

  // ---------------- Result register ----------------
  // Reads the S3 state from the edge that absorbed the last beat; a new
  // vector starting in the same cycle overwrites S3 only after this load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_inf   <= 1'b0;
      out_ovf   <= 1'b0;
      out_beats <= '0;
    end else begin
      out_valid <= s3_done;
      if (s3_done) begin
        out_sum   <= inf_st ? '0 : acc;
        out_inf   <= inf_st;
        out_ovf   <= ovf_st;
        out_beats <= beat_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fp12_dot_accum.sv
// tb_fp12_dot_accum
//   Scoreboard bench for fp12_dot_accum. The driver applies directed and
//   random beats, evaluates each beat with an arithmetic reference model
//   (exact 64-bit sums with range checks) and queues the expected result
//   when a vector closes. A negedge monitor pops and compares every
//   out_valid, and checks that out_sum holds between results.

module tb_fp12_dot_accum;

  localparam int ACC_W = 40;
  localparam int CNT_W = 4;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));
  localparam int BEAT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_last;
  logic [11:0]      pa, pb, pc, pd;
  logic             out_valid;
  logic [ACC_W-1:0] out_sum;
  logic             out_inf, out_ovf;
  logic [CNT_W-1:0] out_beats;

  fp12_dot_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd),
    .out_valid(out_valid), .out_sum(out_sum), .out_inf(out_inf),
    .out_ovf(out_ovf), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             inf;
    logic             ovf;
    logic [CNT_W-1:0] beats;
    int               cyc;
  } exp_t;

  exp_t sb_q[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- Reference model (driver-owned) ----------------
  logic   m_first;
  longint m_acc;
  logic   m_inf, m_ovf;
  int     m_beats;

  function automatic longint lane_value(input logic [11:0] p);
    int     e;
    longint mag;
    e = int'(p[10:6]);
    if (e == 0 || e == 31) return 0;
    mag = longint'(64 + int'(p[5:0])) * (longint'(1) <<< e);
    return p[11] ? -mag : mag;
  endfunction

  function automatic longint wrap_acc(input longint r);
    longint m, w;
    m = longint'(1) <<< ACC_W;
    w = r & (m - 1);
    if (w > ACC_MAX) w = w - m;
    return w;
  endfunction

  task automatic model_beat(input logic [11:0] a, b, c, d, input logic last);
    longint bsum, r;
    logic   binf;
    exp_t   e;
    bsum = lane_value(a) + lane_value(b) + lane_value(c) + lane_value(d);
    binf = (a[10:6] == 5'd31) || (b[10:6] == 5'd31) || (c[10:6] == 5'd31) || (d[10:6] == 5'd31);
    if (m_first) begin
      m_acc = bsum; m_inf = binf; m_ovf = 1'b0; m_beats = 1;
    end else begin
      m_inf   = m_inf | binf;
      m_beats = (m_beats >= BEAT_MAX) ? BEAT_MAX : m_beats + 1;
`ifdef FP12ACC_SAT_EN
      if (!m_ovf) begin
        r = m_acc + bsum;
        if (r > ACC_MAX) begin m_acc = ACC_MAX; m_ovf = 1'b1; end
        else if (r < ACC_MIN) begin m_acc = ACC_MIN; m_ovf = 1'b1; end
        else m_acc = r;
      end
`else
      r = m_acc + bsum;
      if (r > ACC_MAX || r < ACC_MIN) m_ovf = 1'b1;
      m_acc = wrap_acc(r);
`endif
    end
    m_first = last;
    if (last) begin
      e.sum   = m_inf ? '0 : ACC_W'(m_acc);
      e.inf   = m_inf;
      e.ovf   = m_ovf;
      e.beats = CNT_W'(m_beats);
      e.cyc   = cyc + 4;
      sb_q.push_back(e);
    end
  endtask

  // ---------------- Driver helpers ----------------
  task automatic beat(input logic [11:0] a, b, c, d, input logic last);
    @(posedge clk); #1;
    in_valid = 1'b1; in_last = last;
    pa = a; pb = b; pc = c; pd = d;
    model_beat(a, b, c, d, last);
  endtask

  task automatic bubble();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom);
    pa = 12'($urandom); pb = 12'($urandom); pc = 12'($urandom); pd = 12'($urandom);
  endtask

  function automatic logic [11:0] rnd_lane(input int max_exp);
    return {1'($urandom), 5'($urandom_range(0, max_exp)), 6'($urandom)};
  endfunction

  // ---------------- Monitor ----------------
  exp_t             mon_e;
  logic [ACC_W-1:0] held_sum = '0;

  always @(negedge clk) begin
    if (!rst) held_sum = '0;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("out_sum",   64'(out_sum),   64'(mon_e.sum));
        check("out_inf",   64'(out_inf),   64'(mon_e.inf));
        check("out_ovf",   64'(out_ovf),   64'(mon_e.ovf));
        check("out_beats", 64'(out_beats), 64'(mon_e.beats));
        check("latency",   64'(cyc),       64'(mon_e.cyc));
        held_sum = mon_e.sum;
      end
    end else begin
      check("hold_sum", 64'(out_sum), 64'(held_sum));
    end
  end

  // ---------------- Watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

  // ---------------- Stimulus ----------------
  initial begin
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    pa = '0; pb = '0; pc = '0; pd = '0;
    m_first = 1'b1; m_acc = 0; m_inf = 1'b0; m_ovf = 1'b0; m_beats = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_sum",   64'(out_sum),   64'(0));
    check("reset_out_inf",   64'(out_inf),   64'(0));
    check("reset_out_ovf",   64'(out_ovf),   64'(0));
    check("reset_out_beats", 64'(out_beats), 64'(0));
    rst = 1'b1;

    // Single beat of 4 x 1.0
    beat(12'h3C0, 12'h3C0, 12'h3C0, 12'h3C0, 1'b1);
    repeat (5) bubble();

    // Two beats with a bubble between: 1.0 then 1.5
    beat(12'h3C0, 12'h3C0, 12'hBC0, 12'h000, 1'b0);
    bubble();
    beat(12'h3E0, 12'h000, 12'h000, 12'h000, 1'b1);
    repeat (5) bubble();

    // inf in beat 1 of a 3-beat vector, then a clean vector
    beat(12'h7C0, 12'h3C0, 12'h000, 12'h000, 1'b0);
    beat(12'h3C0, 12'h3C0, 12'h3C0, 12'h3C0, 1'b0);
    beat(12'h3C0, 12'h000, 12'h000, 12'h000, 1'b1);
    beat(12'h3C0, 12'h3C0, 12'h000, 12'h000, 1'b1);
    repeat (5) bubble();

    // Overflow: two beats of the largest finite lanes
    beat(12'h7BF, 12'h7BF, 12'h7BF, 12'h7BF, 1'b0);
    beat(12'h7BF, 12'h7BF, 12'h7BF, 12'h7BF, 1'b1);
    // Negative overflow, then a following beat that must not undo the flag
    beat(12'hFBF, 12'hFBF, 12'hFBF, 12'hFBF, 1'b0);
    beat(12'hFBF, 12'hFBF, 12'hFBF, 12'hFBF, 1'b0);
    beat(12'h7BF, 12'h000, 12'h000, 12'h000, 1'b1);
    repeat (5) bubble();

    // Back-to-back single-beat vectors: +4.0 then -4.0
    beat(12'h3C0, 12'h3C0, 12'h3C0, 12'h3C0, 1'b1);
    beat(12'hBC0, 12'hBC0, 12'hBC0, 12'hBC0, 1'b1);
    repeat (5) bubble();

    // Beat counter saturation: 20 beats with small exponents
    for (int i = 0; i < 20; i++)
      beat(rnd_lane(12), rnd_lane(12), rnd_lane(12), rnd_lane(12), logic'(i == 19));
    repeat (5) bubble();

    // Reset mid-vector: partial vector is discarded
    beat(12'h3C0, 12'h3C0, 12'h3C0, 12'h3C0, 1'b0);
    beat(12'h3C0, 12'h3C0, 12'h3C0, 12'h3C0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'(0));
    check("midreset_out_sum",   64'(out_sum),   64'(0));
    check("midreset_out_inf",   64'(out_inf),   64'(0));
    check("midreset_out_ovf",   64'(out_ovf),   64'(0));
    check("midreset_out_beats", 64'(out_beats), 64'(0));
    m_first = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) bubble();
    beat(12'h3C0, 12'h3C0, 12'h3C0, 12'h3C0, 1'b1);
    repeat (5) bubble();

    // Random vectors with random bubbles and back-to-back boundaries
    for (int v = 0; v < 60; v++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) bubble();
        beat(rnd_lane(31), rnd_lane(31), rnd_lane(31), rnd_lane(31), logic'(b == len - 1));
      end
    end

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) bubble();
    check("drain_pending_results", 64'(sb_q.size()), 64'(0));
    repeat (4) bubble();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
